// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 keyboard frame receiver that queues hex-key nibbles in a FWFT FIFO.
// Optional odd-parity rejection is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_fifo #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       full,
    output logic [4:0] count,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_parity;
    logic [TW-1:0]   r_to_cnt;
    logic            r_break;
    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [4:0]      r_count;
    logic            r_overflow;
    logic            r_frame_err;

    logic            w_fall;
    logic            w_timeout;
    logic            w_frame_done;
    logic            w_frame_bad;
    logic            w_parity_ok;
    logic [4:0]      w_map;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_valid;

    function automatic logic [4:0] map_code(input logic [7:0] b);
        case (b)
            8'h45: map_code = 5'h10;
            8'h16: map_code = 5'h11;
            8'h1E: map_code = 5'h12;
            8'h26: map_code = 5'h13;
            8'h25: map_code = 5'h14;
            8'h2E: map_code = 5'h15;
            8'h36: map_code = 5'h16;
            8'h3D: map_code = 5'h17;
            8'h3E: map_code = 5'h18;
            8'h46: map_code = 5'h19;
            8'h1C: map_code = 5'h1A;
            8'h32: map_code = 5'h1B;
            8'h21: map_code = 5'h1C;
            8'h23: map_code = 5'h1D;
            8'h24: map_code = 5'h1E;
            8'h2B: map_code = 5'h1F;
            default: map_code = 5'h00;
        endcase
    endfunction

    // Synchronizers idle high so reset release never looks like a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    // Parity bit is still captured; it simply never vetoes a frame
    assign w_parity_ok = r_parity | 1'b1;
`endif

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_frame_done = 1'b0;
        w_frame_bad  = 1'b0;
        if (r_state != S_IDLE && !w_fall && r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            w_timeout    = 1'b1;
            w_next_state = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_next_state = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_next_state = S_PARITY;
                S_PARITY: w_next_state = S_STOP;
                S_STOP: begin
                    w_next_state = S_IDLE;
                    if (r_dat_s2 && w_parity_ok) w_frame_done = 1'b1;
                    else                         w_frame_bad  = 1'b1;
                end
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_break     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_frame_err <= w_timeout | w_frame_bad;
            if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + 1'b1;
            if (w_timeout) begin
                r_shift   <= 8'h00;
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        r_shift   <= 8'h00;
                        r_bit_cnt <= 3'd0;
                    end
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= r_dat_s2;
                    default: ;
                endcase
            end
            if (w_frame_done) begin
                if (r_shift == 8'hF0)                 r_break <= 1'b1;
                else if (r_shift != 8'hE0 && r_break) r_break <= 1'b0;
            end
        end
    end

    assign w_map      = map_code(r_shift);
    assign w_push_req = w_frame_done && r_shift != 8'hF0 && r_shift != 8'hE0
                        && !r_break && w_map[4];
    assign w_valid    = r_count != 5'd0;
    assign w_full     = r_count == 5'(DEPTH);
    assign w_pop      = rd_en & w_valid;
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_map[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign key_valid = w_valid;
    assign key_data  = w_valid ? r_mem[r_rd_ptr] : 4'h0;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - Directed table-driven bench for ps2_key_fifo.
module tb_ps2_key_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [3:0] key_data;
    logic       key_valid, full, overflow, frame_err;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int e0;

    typedef struct {
        logic [7:0] code;
        logic       exp_valid;
        logic [3:0] exp_nib;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] mk   [16];

    ps2_key_fifo #(.DEPTH(8), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .key_data(key_data), .key_valid(key_valid), .full(full), .count(count),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) err_pulses++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sends the first nbits of {stop, parity, data, start}; optionally pops in the push cycle
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input int nbits, input logic pop_at_stop);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = f[i];
            repeat (3) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                @(posedge clk);
                @(posedge clk); #1 rd_en = 1'b1;
                @(posedge clk); #1 rd_en = 1'b0;
                repeat (5) @(posedge clk);
            end else begin
                repeat (8) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
            repeat (3) @(posedge clk);
        end
        #1 ps2_data = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic pop();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        mk[0]  = 8'h45; mk[1]  = 8'h16; mk[2]  = 8'h1E; mk[3]  = 8'h26;
        mk[4]  = 8'h25; mk[5]  = 8'h2E; mk[6]  = 8'h36; mk[7]  = 8'h3D;
        mk[8]  = 8'h3E; mk[9]  = 8'h46; mk[10] = 8'h1C; mk[11] = 8'h32;
        mk[12] = 8'h21; mk[13] = 8'h23; mk[14] = 8'h24; mk[15] = 8'h2B;
        vecs[0]  = '{8'h16, 1'b1, 4'h1};
        vecs[1]  = '{8'h45, 1'b1, 4'h0};
        vecs[2]  = '{8'h46, 1'b1, 4'h9};
        vecs[3]  = '{8'h1C, 1'b1, 4'hA};
        vecs[4]  = '{8'h32, 1'b1, 4'hB};
        vecs[5]  = '{8'h21, 1'b1, 4'hC};
        vecs[6]  = '{8'h23, 1'b1, 4'hD};
        vecs[7]  = '{8'h2B, 1'b1, 4'hF};
        vecs[8]  = '{8'h3D, 1'b1, 4'h7};
        vecs[9]  = '{8'h12, 1'b0, 4'h0};
        vecs[10] = '{8'h00, 1'b0, 4'h0};
        vecs[11] = '{8'hE0, 1'b0, 4'h0};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", key_valid, 0);
        chk("rst_data", key_data, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);

        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].code, 1'b0, 1'b1, 11, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), key_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_data", i), key_data, vecs[i].exp_valid ? vecs[i].exp_nib : 4'h0);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_valid ? 1 : 0);
            if (vecs[i].exp_valid) pop();
        end

        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("k16_valid", key_valid, 1);
        chk("k16_data", key_data, 1);
        pop();
        chk("k16_pop_valid", key_valid, 0);
        chk("k16_pop_data", key_data, 0);
        pop();
        chk("underflow_count", count, 0);

        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("rel_count", count, 1);
        chk("rel_data", key_data, 4'hA);
        send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h2B, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("ext_count", count, 2);
        pop();
        chk("ext_data", key_data, 4'hF);
        pop();

        for (int i = 0; i < 9; i++) send_frame(mk[i], 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("order%0d", i), key_data, i);
            pop();
        end
        chk("drain_valid", key_valid, 0);
        pop();
        chk("drain_count", count, 0);
        chk("ovf_sticky", overflow, 1);
        do_reset();
        chk("ovf_cleared", overflow, 0);

        for (int i = 0; i < 8; i++) send_frame(mk[i], 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h2B, 1'b0, 1'b1, 11, 1'b1);
        @(negedge clk);
        chk("fullpp_count", count, 8);
        chk("fullpp_ovf", overflow, 0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("fullpp_order%0d", i), key_data, i);
            pop();
        end
        chk("fullpp_tail", key_data, 4'hF);
        pop();
        chk("fullpp_empty", count, 0);

        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h1E, 1'b0, 1'b1, 11, 1'b1);
        @(negedge clk);
        chk("one_pp_count", count, 1);
        chk("one_pp_data", key_data, 2);
        pop();

        e0 = err_pulses;
        send_frame(8'h16, 1'b0, 1'b0, 11, 1'b0);
        @(negedge clk);
        chk("stop0_err", err_pulses - e0, 1);
        chk("stop0_count", count, 0);

        e0 = err_pulses;
        send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0);
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("timeout_err", err_pulses - e0, 1);
        chk("timeout_count", count, 0);
        send_frame(8'h45, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("after_to_count", count, 1);
        chk("after_to_data", key_data, 0);
        pop();

        send_frame(8'h26, 1'b0, 1'b1, 6, 1'b0);
        do_reset();
        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("midrst_count", count, 1);
        chk("midrst_data", key_data, 1);
        do_reset();

        e0 = err_pulses;
        send_frame(8'h16, 1'b1, 1'b1, 11, 1'b0);
        @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_count", count, 0);
        chk("par_err", err_pulses - e0, 1);
`else
        chk("par_count", count, 1);
        chk("par_err", err_pulses - e0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
